// File: rtl/nec_ir_pkg.sv
// Shared types for the NEC IR transmitter: FSM state encoding, segment lengths in units,
// and small decode helpers used by the top level.
package nec_ir_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD_MARK,
        ST_LEAD_SPACE,
        ST_BIT_MARK,
        ST_BIT_SPACE,
        ST_STOP_MARK
    } nec_state_e;

    localparam int unsigned LEAD_MARK_U    = 16;
    localparam int unsigned LEAD_SPACE_U   = 8;
    localparam int unsigned REPEAT_SPACE_U = 4;
    localparam int unsigned BIT_MARK_U     = 1;
    localparam int unsigned ZERO_SPACE_U   = 1;
    localparam int unsigned ONE_SPACE_U    = 3;
    localparam int unsigned STOP_MARK_U    = 1;
    localparam int unsigned FRAME_BITS     = 32;

    // Wide enough for the longest segment (the 16-unit leader mark).
    localparam int unsigned UNIT_W = 5;
    localparam int unsigned BIDX_W = $clog2(FRAME_BITS);

    function automatic logic [UNIT_W-1:0] seg_units(input nec_state_e st,
                                                    input logic       is_repeat,
                                                    input logic       cur_bit);
        logic [UNIT_W-1:0] n;
        n = UNIT_W'(1);
        case (st)
            ST_LEAD_MARK:  n = UNIT_W'(LEAD_MARK_U);
            ST_LEAD_SPACE: n = is_repeat ? UNIT_W'(REPEAT_SPACE_U) : UNIT_W'(LEAD_SPACE_U);
            ST_BIT_MARK:   n = UNIT_W'(BIT_MARK_U);
            ST_BIT_SPACE:  n = cur_bit ? UNIT_W'(ONE_SPACE_U) : UNIT_W'(ZERO_SPACE_U);
            ST_STOP_MARK:  n = UNIT_W'(STOP_MARK_U);
            default:       n = UNIT_W'(1);
        endcase
        return n;
    endfunction

    function automatic logic is_mark(input nec_state_e st);
        return (st == ST_LEAD_MARK) || (st == ST_BIT_MARK) || (st == ST_STOP_MARK);
    endfunction

endpackage

// File: rtl/nec_ir_frame_tx_if.sv
// Request handshake between the register/bus side (master) and the NEC IR transmitter (slave).
interface nec_ir_frame_tx_if #(
    parameter int PBITS = 16
);
    logic [31:0]      i_data;
    logic             i_repeat;
    logic             i_valid;
    logic [PBITS-1:0] prescaler;
    logic             o_ready;

    modport master (output i_data, i_repeat, i_valid, prescaler, input o_ready);
    modport slave  (input i_data, i_repeat, i_valid, prescaler, output o_ready);
endinterface

// File: rtl/nec_ir_frame_tx_unit_timer.sv
// Unit prescaler: cycle counter running 0..prescaler, one tick per (prescaler+1) clk.
module nec_ir_unit_timer #(
    parameter int PBITS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_n,
    input  logic             restart,
    input  logic [PBITS-1:0] prescaler,
    output logic             tick
);
    logic [PBITS-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == prescaler);

    always_comb begin
        cnt_d = cnt_q + PBITS'(1);
        if (restart || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (!clear_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/nec_ir_frame_tx.sv
// NEC IR transmitter: serialises a 32-bit frame (LSB first) or a repeat code into ir_tx.
// Define NEC_IR_TX_CARRIER_EN to gate marks with a 50% carrier set by carrier_div.
module nec_ir_frame_tx
    import nec_ir_pkg::*;
#(
    parameter int PBITS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_n,
    nec_ir_frame_tx_if.slave bus,
`ifdef NEC_IR_TX_CARRIER_EN
    input  logic [PBITS-1:0] carrier_div,
`endif
    output logic             ir_tx,
    output logic             busy,
    output logic             done
);
    nec_state_e            state_q, state_d;
    logic [UNIT_W-1:0]     unit_q, unit_d;
    logic [BIDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic                  repeat_q, repeat_d;
    logic [PBITS-1:0]      presc_q, presc_d;
    logic                  done_q, done_d;
    logic                  ir_tx_q, ir_tx_d;
    logic                  accept, tick, seg_end, mark_d;
    logic [UNIT_W-1:0]     seg_last;

    assign bus.o_ready = (state_q == ST_IDLE);
    assign accept      = bus.i_valid && (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;
    assign ir_tx       = ir_tx_q;

    // Held in restart while idle so every frame starts on a full unit.
    nec_ir_unit_timer #(.PBITS(PBITS)) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_n   (clear_n),
        .restart   (state_q == ST_IDLE),
        .prescaler (presc_q),
        .tick      (tick)
    );

    assign seg_last = seg_units(state_q, repeat_q, shift_q[0]) - UNIT_W'(1);
    assign seg_end  = tick && (unit_q == seg_last);
    assign mark_d   = is_mark(state_d);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        unit_d    = unit_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        repeat_d  = repeat_q;
        presc_d   = presc_q;
        done_d    = 1'b0;

        if (state_q != ST_IDLE && tick) begin
            unit_d = seg_end ? '0 : unit_q + UNIT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d   = ST_LEAD_MARK;
                    shift_d   = bus.i_data;
                    repeat_d  = bus.i_repeat;
                    presc_d   = bus.prescaler;
                    unit_d    = '0;
                    bit_idx_d = '0;
                end
            end
            ST_LEAD_MARK:  if (seg_end) state_d = ST_LEAD_SPACE;
            ST_LEAD_SPACE: if (seg_end) state_d = repeat_q ? ST_STOP_MARK : ST_BIT_MARK;
            ST_BIT_MARK:   if (seg_end) state_d = ST_BIT_SPACE;
            ST_BIT_SPACE: begin
                if (seg_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q < BIDX_W'(FRAME_BITS - 1)) begin
                        bit_idx_d = bit_idx_q + BIDX_W'(1);
                        state_d   = ST_BIT_MARK;
                    end else begin
                        state_d = ST_STOP_MARK;
                    end
                end
            end
            ST_STOP_MARK: begin
                if (seg_end) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef NEC_IR_TX_CARRIER_EN
    logic [PBITS-1:0] cdiv_q, cdiv_d, ccnt_q, ccnt_d;
    logic             phase_q, phase_d;

    // Mark states are never adjacent, so a mark start is simply "mark next, not mark now".
    always_comb begin
        cdiv_d  = accept ? carrier_div : cdiv_q;
        ccnt_d  = '0;
        phase_d = 1'b0;
        if (mark_d && !is_mark(state_q)) begin
            phase_d = 1'b1;
        end else if (mark_d) begin
            if (ccnt_q == cdiv_q) begin
                phase_d = ~phase_q;
            end else begin
                ccnt_d  = ccnt_q + PBITS'(1);
                phase_d = phase_q;
            end
        end
        ir_tx_d = mark_d & phase_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cdiv_q  <= '0;
            ccnt_q  <= '0;
            phase_q <= 1'b0;
        end else if (!clear_n) begin
            cdiv_q  <= '0;
            ccnt_q  <= '0;
            phase_q <= 1'b0;
        end else begin
            cdiv_q  <= cdiv_d;
            ccnt_q  <= ccnt_d;
            phase_q <= phase_d;
        end
    end
`else
    assign ir_tx_d = mark_d;
`endif

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            unit_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            repeat_q  <= 1'b0;
            presc_q   <= '0;
            done_q    <= 1'b0;
            ir_tx_q   <= 1'b0;
        end else if (!clear_n) begin
            state_q   <= ST_IDLE;
            unit_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            repeat_q  <= 1'b0;
            presc_q   <= '0;
            done_q    <= 1'b0;
            ir_tx_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            unit_q    <= unit_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            repeat_q  <= repeat_d;
            presc_q   <= presc_d;
            done_q    <= done_d;
            ir_tx_q   <= ir_tx_d;
        end
    end
endmodule

// File: tb/tb_nec_ir_frame_tx.sv
// Scoreboard bench for nec_ir_frame_tx: stimulus queues the expected per-cycle ir_tx waveform
// and done latency; a monitor pops and compares every cycle while busy and on each done pulse.
module tb_nec_ir_frame_tx;
    localparam int PBITS = 16;
`ifdef NEC_IR_TX_CARRIER_EN
    localparam int CDIV = 1;
    logic [PBITS-1:0] carrier_div;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear_n = 1'b1;
    logic ir_tx, busy, done;

    nec_ir_frame_tx_if #(.PBITS(PBITS)) bus ();

    nec_ir_frame_tx #(.PBITS(PBITS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_n     (clear_n),
        .bus         (bus),
`ifdef NEC_IR_TX_CARRIER_EN
        .carrier_div (carrier_div),
`endif
        .ir_tx       (ir_tx),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    bit exp_bits[$];
    int exp_done[$];
    int tests = 0;
    int fails = 0;
    int last_accept = 0;
    int push_n, push_limit;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected ir_tx for one segment; a mark is optionally gated by the carrier phase.
    task automatic add_seg(input bit m, input int len);
        for (int k = 0; k < len; k++) begin
            bit b;
`ifdef NEC_IR_TX_CARRIER_EN
            b = m && (((k / (CDIV + 1)) % 2) == 0);
`else
            b = m;
`endif
            if (push_n < push_limit) begin
                exp_bits.push_back(b);
                push_n++;
            end
        end
    endtask

    task automatic push_frame(input logic [31:0] data, input bit rep, input int p, input int limit);
        int u;
        u = p + 1;
        push_n = 0;
        push_limit = limit;
        add_seg(1'b1, 16 * u);
        add_seg(1'b0, (rep ? 4 : 8) * u);
        if (!rep) begin
            for (int i = 0; i < 32; i++) begin
                add_seg(1'b1, u);
                add_seg(1'b0, data[i] ? 3 * u : u);
            end
        end
        add_seg(1'b1, u);
    endtask

    task automatic wait_accept();
        for (int k = 0; k <= 3000; k++) begin
            @(negedge clk);
            if (bus.o_ready === 1'b1) return;
        end
        check("accept timeout", {31'd0, bus.o_ready}, 32'd1);
    endtask

    task automatic wait_idle();
        for (int k = 0; k <= 3000; k++) begin
            @(negedge clk);
            if (bus.o_ready === 1'b1) begin
                repeat (3) @(posedge clk);
                #1;
                return;
            end
        end
        check("idle timeout", {31'd0, bus.o_ready}, 32'd1);
    endtask

    task automatic send(input logic [31:0] data, input bit rep, input int p, input int lat);
        push_frame(data, rep, p, 1 << 20);
        exp_done.push_back(lat);
        bus.i_data    = data;
        bus.i_repeat  = rep;
        bus.prescaler = PBITS'(p);
        bus.i_valid   = 1'b1;
        wait_accept();
        @(posedge clk);
        #1;
        bus.i_valid  = 1'b0;
        bus.i_data   = ~data;
        bus.i_repeat = ~rep;
    endtask

    // Monitor: done is handled before accept bookkeeping so a same-cycle re-accept is not confused.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done === 1'b1) begin
                if (exp_done.size() == 0) check("unexpected done", {31'd0, done}, 32'd0);
                else check("done latency", cyc - last_accept, exp_done.pop_front());
            end
            if (bus.i_valid && bus.o_ready && clear_n) last_accept = cyc + 1;
            if (busy === 1'b1) begin
                if (exp_bits.size() == 0) check("busy beyond expected frame", {31'd0, busy}, 32'd0);
                else check("ir_tx while busy", {31'd0, ir_tx}, {31'd0, exp_bits.pop_front()});
            end else begin
                check("ir_tx while idle", {31'd0, ir_tx}, 32'd0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_valid   = 1'b0;
        bus.i_data    = '0;
        bus.i_repeat  = 1'b0;
        bus.prescaler = '0;
`ifdef NEC_IR_TX_CARRIER_EN
        carrier_div = PBITS'(CDIV);
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset ir_tx", {31'd0, ir_tx}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset o_ready", {31'd0, bus.o_ready}, 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("post-reset ir_tx", {31'd0, ir_tx}, 32'd0);
        check("post-reset busy", {31'd0, busy}, 32'd0);
        check("post-reset done", {31'd0, done}, 32'd0);
        check("post-reset o_ready", {31'd0, bus.o_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Directed frames: (25 + 2*zeros + 4*ones) units, or 21 for repeat, times (p+1).
        send(32'h00FF00FF, 1'b0, 3, 484); wait_idle();
        send(32'hDEADBEEF, 1'b1, 3, 84);  wait_idle();
        send(32'h12345678, 1'b0, 1, 230); wait_idle();
        send(32'hFFFFFFFF, 1'b0, 0, 153); wait_idle();

        // Held request: second frame may only be taken in the done cycle.
        push_frame(32'hA5A5A5A5, 1'b0, 2, 1 << 20);
        exp_done.push_back(363);
        push_frame(32'h00FF00FF, 1'b0, 3, 1 << 20);
        exp_done.push_back(484);
        bus.i_data    = 32'hA5A5A5A5;
        bus.i_repeat  = 1'b0;
        bus.prescaler = PBITS'(2);
        bus.i_valid   = 1'b1;
        wait_accept();
        @(posedge clk);
        #1;
        bus.i_data    = 32'h00FF00FF;
        bus.prescaler = PBITS'(3);
        wait_accept();
        check("back-to-back accept in done cycle", {31'd0, done}, 32'd1);
        @(posedge clk);
        #1 bus.i_valid = 1'b0;
        @(negedge clk);
        check("ir_tx rises cycle after done", {31'd0, ir_tx}, 32'd1);
        wait_idle();

        // Abort in bit 10's mark (cycles 241..244 after accept); clear sampled at the end of 242.
        push_frame(32'h00FF00FF, 1'b0, 3, 242);
        bus.i_data    = 32'h00FF00FF;
        bus.i_repeat  = 1'b0;
        bus.prescaler = PBITS'(3);
        bus.i_valid   = 1'b1;
        wait_accept();
        @(posedge clk);
        #1 bus.i_valid = 1'b0;
        repeat (241) @(posedge clk);
        #1 clear_n = 1'b0;
        @(posedge clk);
        #1 clear_n = 1'b1;
        @(negedge clk);
        check("abort ir_tx", {31'd0, ir_tx}, 32'd0);
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort o_ready", {31'd0, bus.o_ready}, 32'd1);
        check("abort done", {31'd0, done}, 32'd0);
        repeat (600) @(posedge clk);
        #1;

        send(32'h0F0F0F0F, 1'b1, 0, 21); wait_idle();

        repeat (10) @(posedge clk);
        check("leftover expected ir_tx cycles", exp_bits.size(), 0);
        check("leftover expected done pulses", exp_done.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
